// File: rtl/global_mem_arbiter.sv
// Shared word-addressed memory with one pending slot per core, a single
// round-robin service engine of fixed latency, and a zero-latency controller port.
module global_mem_arbiter #(
  parameter int num_cores           = 4,
  parameter int addr_width          = 32,
  parameter int data_width          = 32,
  parameter int memory_size         = 4096,
  parameter int mem_simulated_delay = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [num_cores-1:0]             core_rd_req,
  input  logic [num_cores-1:0]             core_wr_req,
  input  logic [num_cores*addr_width-1:0]  core_addr,
  input  logic [num_cores*data_width-1:0]  core_wr_data,
  output logic [num_cores*data_width-1:0]  core_rd_data,
  output logic [num_cores-1:0]             core_busy,
  output logic [num_cores-1:0]             core_ack,
  input  logic                             contr_wr_en,
  input  logic                             contr_rd_en,
  input  logic [addr_width-1:0]            contr_wr_addr,
  input  logic [addr_width-1:0]            contr_rd_addr,
  input  logic [data_width-1:0]            contr_wr_data,
  output logic [data_width-1:0]            contr_rd_data,
  output logic                             contr_rd_ack
);

  localparam int idx_w = (memory_size > 1) ? $clog2(memory_size) : 1;
  localparam int gnt_w = (num_cores > 1) ? $clog2(num_cores) : 1;
  localparam int cnt_w = $clog2(mem_simulated_delay + 1);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t                                 state_q, state_d;
  logic [cnt_w-1:0]                       cnt_q, cnt_d;
  logic [gnt_w-1:0]                       grant_q, grant_d;
  logic [gnt_w-1:0]                       last_grant_q, last_grant_d;
  logic [num_cores-1:0]                   slot_v_q, slot_v_d;
  logic [num_cores-1:0]                   slot_wr_q, slot_wr_d;
  logic [num_cores-1:0][idx_w-1:0]        slot_addr_q, slot_addr_d;
  logic [num_cores-1:0][data_width-1:0]   slot_data_q, slot_data_d;
  logic [num_cores-1:0]                   ack_q, ack_d;
  logic                                   ack_rd_q, ack_rd_d;
  logic                                   contr_ack_q, contr_ack_d;
  logic                                   complete;
  logic                                   found;
  logic [gnt_w-1:0]                       sel;

  logic [data_width-1:0]                  mem [memory_size];
  logic [data_width-1:0]                  mem_rd_q;
  logic [data_width-1:0]                  contr_rd_q;

  // Upper address bits alias onto the memory; only the word index is used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{core_addr, contr_wr_addr, contr_rd_addr};

  assign complete = (state_q == SERVE) && (cnt_q == '0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    slot_v_d     = slot_v_q;
    slot_wr_d    = slot_wr_q;
    slot_addr_d  = slot_addr_q;
    slot_data_d  = slot_data_q;
    ack_d        = '0;
    ack_rd_d     = 1'b0;
    contr_ack_d  = contr_rd_en;
    found        = 1'b0;
    sel          = '0;

    if (complete) begin
      slot_v_d[grant_q] = 1'b0;
      ack_d[grant_q]    = 1'b1;
      ack_rd_d          = !slot_wr_q[grant_q];
    end

    for (int i = 0; i < num_cores; i++) begin
      if (!slot_v_q[i] && (core_rd_req[i] || core_wr_req[i])) begin
        slot_v_d[i]    = 1'b1;
        slot_wr_d[i]   = core_wr_req[i];
        slot_addr_d[i] = core_addr[i*addr_width+2 +: idx_w];
        slot_data_d[i] = core_wr_data[i*data_width +: data_width];
      end
    end

    // The post-update slot set already excludes the completing core and
    // includes fresh captures, so it is exactly the grantable set.
    for (int k = 1; k <= num_cores; k++) begin
      int cand;
      cand = (int'(last_grant_q) + k) % num_cores;
      if (!found && slot_v_d[cand]) begin
        found = 1'b1;
        sel   = gnt_w'(cand);
      end
    end

    if ((state_q == IDLE || complete) && found) begin
      state_d      = SERVE;
      cnt_d        = cnt_w'(mem_simulated_delay - 1);
      grant_d      = sel;
      last_grant_d = sel;
    end else if (complete) begin
      state_d = IDLE;
    end else if (state_q == SERVE) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      grant_q      <= '0;
      last_grant_q <= gnt_w'(num_cores - 1);
      slot_v_q     <= '0;
      slot_wr_q    <= '0;
      slot_addr_q  <= '0;
      slot_data_q  <= '0;
      ack_q        <= '0;
      ack_rd_q     <= 1'b0;
      contr_ack_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      slot_v_q     <= slot_v_d;
      slot_wr_q    <= slot_wr_d;
      slot_addr_q  <= slot_addr_d;
      slot_data_q  <= slot_data_d;
      ack_q        <= ack_d;
      ack_rd_q     <= ack_rd_d;
      contr_ack_q  <= contr_ack_d;
    end
  end

  // Controller write is ordered last so it wins a same-word collision;
  // reads see pre-edge contents.
  always_ff @(posedge clk) begin
    if (complete && slot_wr_q[grant_q]) begin
      mem[slot_addr_q[grant_q]] <= slot_data_q[grant_q];
    end
    if (contr_wr_en) begin
      mem[contr_wr_addr[2 +: idx_w]] <= contr_wr_data;
    end
    mem_rd_q   <= mem[slot_addr_q[grant_q]];
    contr_rd_q <= mem[contr_rd_addr[2 +: idx_w]];
  end

  assign core_busy     = slot_v_q;
  assign core_ack      = ack_q;
  assign contr_rd_ack  = contr_ack_q;
  assign contr_rd_data = contr_ack_q ? contr_rd_q : '0;

  for (genvar gi = 0; gi < num_cores; gi++) begin : g_rd_data
    assign core_rd_data[gi*data_width +: data_width] =
      (ack_q[gi] && ack_rd_q) ? mem_rd_q : '0;
  end

endmodule

// File: tb/tb_global_mem_arbiter.sv
// Directed bench for global_mem_arbiter: two cores, latency 5, 64-word memory.
module tb_global_mem_arbiter;

  localparam int NC = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MS = 64;
  localparam int D  = 5;

  logic               clk;
  logic               rst;
  logic [NC-1:0]      core_rd_req;
  logic [NC-1:0]      core_wr_req;
  logic [NC*AW-1:0]   core_addr;
  logic [NC*DW-1:0]   core_wr_data;
  logic [NC*DW-1:0]   core_rd_data;
  logic [NC-1:0]      core_busy;
  logic [NC-1:0]      core_ack;
  logic               contr_wr_en;
  logic               contr_rd_en;
  logic [AW-1:0]      contr_wr_addr;
  logic [AW-1:0]      contr_rd_addr;
  logic [DW-1:0]      contr_wr_data;
  logic [DW-1:0]      contr_rd_data;
  logic               contr_rd_ack;

  int checks   = 0;
  int failures = 0;

  global_mem_arbiter #(
    .num_cores(NC), .addr_width(AW), .data_width(DW),
    .memory_size(MS), .mem_simulated_delay(D)
  ) dut (
    .clk(clk), .rst(rst),
    .core_rd_req(core_rd_req), .core_wr_req(core_wr_req),
    .core_addr(core_addr), .core_wr_data(core_wr_data),
    .core_rd_data(core_rd_data), .core_busy(core_busy), .core_ack(core_ack),
    .contr_wr_en(contr_wr_en), .contr_rd_en(contr_rd_en),
    .contr_wr_addr(contr_wr_addr), .contr_rd_addr(contr_rd_addr),
    .contr_wr_data(contr_wr_data), .contr_rd_data(contr_rd_data),
    .contr_rd_ack(contr_rd_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int c, input bit wr, input logic [31:0] a, input logic [31:0] d);
    core_rd_req[c]         = !wr;
    core_wr_req[c]         = wr;
    core_addr[c*AW +: AW]  = a;
    core_wr_data[c*DW +: DW] = d;
    $display("TXN core%0d %s addr=0x%0h data=0x%0h", c, wr ? "WR" : "RD", a, d);
  endtask

  task automatic clear_reqs();
    core_rd_req = '0;
    core_wr_req = '0;
  endtask

  task automatic contr_write(input logic [31:0] a, input logic [31:0] d);
    contr_wr_en   = 1'b1;
    contr_wr_addr = a;
    contr_wr_data = d;
    tick();
    contr_wr_en   = 1'b0;
    $display("TXN contr WR addr=0x%0h data=0x%0h", a, d);
  endtask

  task automatic contr_read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    contr_rd_en   = 1'b1;
    contr_rd_addr = a;
    tick();
    contr_rd_en   = 1'b0;
    check({tag, "_cack"}, contr_rd_ack, 1'b1);
    check({tag, "_cdata"}, contr_rd_data, exp);
    $display("TXN contr RD addr=0x%0h data=0x%0h", a, contr_rd_data);
  endtask

  // Called just after the edge n cycles before the expected ack.
  task automatic expect_ack(input string tag, input int n, input logic [1:0] exp_busy,
                            input logic [1:0] exp_ack, input logic [63:0] exp_rd);
    for (int k = 1; k < n; k++) begin
      tick();
      check({tag, "_early_ack"}, core_ack, 2'b00);
      check({tag, "_busy"}, core_busy, exp_busy);
    end
    tick();
    check({tag, "_ack"}, core_ack, exp_ack);
    check({tag, "_rdata"}, core_rd_data, exp_rd);
  endtask

  task automatic read_pair();
    issue(0, 1'b0, 32'h10, 32'h0);
    issue(1, 1'b0, 32'h14, 32'h0);
    tick();
    clear_reqs();
  endtask

  initial begin
    rst           = 1'b0;
    core_rd_req   = '0;
    core_wr_req   = '0;
    core_addr     = '0;
    core_wr_data  = '0;
    contr_wr_en   = 1'b0;
    contr_rd_en   = 1'b0;
    contr_wr_addr = '0;
    contr_rd_addr = '0;
    contr_wr_data = '0;

    tick();
    tick();
    check("rst_busy", core_busy, 2'b00);
    check("rst_ack", core_ack, 2'b00);
    check("rst_rdata", core_rd_data, 64'h0);
    check("rst_cack", contr_rd_ack, 1'b0);
    check("rst_cdata", contr_rd_data, 32'h0);
    rst = 1'b1;
    tick();

    contr_write(32'h10, 32'hAB);
    contr_write(32'h14, 32'hCD);

    // After reset core 0 wins a tie; the second core is granted back-to-back.
    read_pair();
    check("p1_busy0", core_busy, 2'b11);
    expect_ack("p1_c0", D, 2'b11, 2'b01, {32'h0, 32'hAB});
    check("p1_busy1", core_busy, 2'b10);
    expect_ack("p1_c1", D, 2'b10, 2'b10, {32'hCD, 32'h0});
    check("p1_busy2", core_busy, 2'b00);

    read_pair();
    expect_ack("p2_c0", D, 2'b11, 2'b01, {32'h0, 32'hAB});
    expect_ack("p2_c1", D, 2'b10, 2'b10, {32'hCD, 32'h0});

    // Single read by core 0, then a tie must go to core 1.
    issue(0, 1'b0, 32'h10, 32'h0);
    tick();
    clear_reqs();
    check("s0_busy", core_busy, 2'b01);
    expect_ack("s0", D, 2'b01, 2'b01, {32'h0, 32'hAB});
    tick();
    check("s0_ack_drop", core_ack, 2'b00);
    check("s0_rdata_drop", core_rd_data, 64'h0);

    read_pair();
    expect_ack("p3_c1", D, 2'b11, 2'b10, {32'hCD, 32'h0});
    expect_ack("p3_c0", D, 2'b01, 2'b01, {32'h0, 32'hAB});

    // Second write while slot busy is dropped.
    issue(1, 1'b1, 32'h20, 32'h55);
    tick();
    clear_reqs();
    issue(1, 1'b1, 32'h20, 32'h66);
    tick();
    clear_reqs();
    expect_ack("w55", D - 1, 2'b10, 2'b10, 64'h0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("w66_no_ack", core_ack, 2'b00);
    end
    contr_read_check("w55_mem", 32'h20, 32'h55);

    // Controller write collides with core write completion on one word.
    issue(0, 1'b1, 32'h30, 32'h2);
    tick();
    clear_reqs();
    repeat (D - 1) tick();
    contr_wr_en   = 1'b1;
    contr_wr_addr = 32'h30;
    contr_wr_data = 32'h1;
    tick();
    contr_wr_en   = 1'b0;
    check("coll_ack", core_ack, 2'b01);
    check("coll_rdata", core_rd_data, 64'h0);
    contr_read_check("coll_mem", 32'h30, 32'h1);
    tick();
    check("coll_cack_drop", contr_rd_ack, 1'b0);

    // Same-edge controller read, controller write and core read completion.
    issue(0, 1'b0, 32'h30, 32'h0);
    tick();
    clear_reqs();
    repeat (D - 1) tick();
    contr_wr_en   = 1'b1;
    contr_wr_addr = 32'h30;
    contr_wr_data = 32'h3;
    contr_rd_en   = 1'b1;
    contr_rd_addr = 32'h30;
    tick();
    contr_wr_en   = 1'b0;
    contr_rd_en   = 1'b0;
    check("rbw_ack", core_ack, 2'b01);
    check("rbw_rdata", core_rd_data, {32'h0, 32'h1});
    check("rbw_cdata", contr_rd_data, 32'h1);
    contr_read_check("rbw_mem", 32'h30, 32'h3);

    // Reset in the middle of a write aborts it.
    issue(0, 1'b1, 32'h10, 32'h77);
    tick();
    clear_reqs();
    tick();
    #2 rst = 1'b0;
    #1;
    check("abort_busy", core_busy, 2'b00);
    check("abort_ack", core_ack, 2'b00);
    tick();
    tick();
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("abort_no_ack", core_ack, 2'b00);
      check("abort_no_busy", core_busy, 2'b00);
    end
    contr_read_check("abort_mem10", 32'h10, 32'hAB);
    contr_read_check("abort_mem14", 32'h14, 32'hCD);

    // Address 4*MS+8 wraps onto word 2.
    contr_write(4 * MS + 8, 32'h99);
    contr_read_check("alias_c", 32'h8, 32'h99);
    issue(0, 1'b0, 4 * MS + 8, 32'h0);
    tick();
    clear_reqs();
    expect_ack("alias_core", D, 2'b01, 2'b01, {32'h0, 32'h99});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
